// File: rtl/conf_bus_master_if.sv
// Request/response handshake and pixel-core configuration bus of conf_bus_master.
// The master modport is the block's view; the slave modport is the requester/chain view.
interface conf_bus_master_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqData;
  logic              ReqDefConf;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              RspErr;
  logic [ADDR_W-1:0] AddressConf;
  logic [DATA_W-1:0] DataConfWr;
  logic              ConfWr;
  logic              DefConf;
  logic [DATA_W-1:0] DataConfRd;
  logic              Busy;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, ReqDefConf, DataConfRd,
    output ReqReady, RspValid, RspData, RspErr, AddressConf, DataConfWr,
           ConfWr, DefConf, Busy
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqData, ReqDefConf, DataConfRd,
    input  ReqReady, RspValid, RspData, RspErr, AddressConf, DataConfWr,
           ConfWr, DefConf, Busy
  );
endinterface

// File: rtl/conf_bus_master.sv
// Periphery initiator for the daisy-chained pixel configuration bus.
// Optional write readback check enabled by defining CONF_RDBACK_CHECK_EN.
module conf_bus_master #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WR_PULSE  = 2,
  parameter int unsigned RD_LAT    = 4
) (
  input  logic              Clk,
  input  logic              Reset_B,
  conf_bus_master_if.master bus
);

  localparam int unsigned MAXP0 = (SETUP_CYC > WR_PULSE) ? SETUP_CYC : WR_PULSE;
  localparam int unsigned MAXP  = (MAXP0 > RD_LAT) ? MAXP0 : RD_LAT;
  localparam int unsigned CNT_W = $clog2(MAXP) + 1;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RDWAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rstn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q, def_q;
  logic              conf_wr_q, def_conf_q, rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              accept, capture;

  // rstn_q gives the synchronous release: no request is taken until the first edge after Reset_B rises.
  assign bus.ReqReady = rstn_q && (state_q == IDLE);
  assign accept       = bus.ReqValid && bus.ReqReady;
  assign capture      = (state_q == RDWAIT) && (cnt_q == RD_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = SETUP;
      SETUP:  if (cnt_q == SETUP_LAST) state_d = (write_q || def_q) ? STROBE : RDWAIT;
      STROBE: if (cnt_q == STROBE_LAST) state_d = HOLD;
`ifdef CONF_RDBACK_CHECK_EN
      HOLD:   state_d = (write_q && !def_q) ? RDWAIT : RESP;
`else
      HOLD:   state_d = RESP;
`endif
      RDWAIT: if (cnt_q == RD_LAST) state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_B) begin
    if (!Reset_B) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rstn_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      def_q       <= 1'b0;
      conf_wr_q   <= 1'b0;
      def_conf_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rstn_q  <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= bus.ReqAddr;
        data_q  <= bus.ReqData;
        write_q <= bus.ReqWrite;
        def_q   <= bus.ReqDefConf;
      end
      // Strobes are decoded from the next state so they leave flops directly.
      conf_wr_q   <= (state_d == STROBE) && !def_q;
      def_conf_q  <= (state_d == STROBE) && def_q;
      rsp_valid_q <= (state_d == RESP);
      if (capture)
        rsp_data_q <= bus.DataConfRd;
      else if ((state_q == HOLD) && (state_d == RESP))
        rsp_data_q <= '0;
    end
  end

`ifdef CONF_RDBACK_CHECK_EN
  logic rsp_err_q;
  always_ff @(posedge Clk or negedge Reset_B) begin
    if (!Reset_B)
      rsp_err_q <= 1'b0;
    else if (capture)
      rsp_err_q <= write_q && !def_q && (bus.DataConfRd != data_q);
    else if ((state_q == HOLD) && (state_d == RESP))
      rsp_err_q <= 1'b0;
  end
  assign bus.RspErr = rsp_err_q;
`else
  assign bus.RspErr = 1'b0;
`endif

  assign bus.AddressConf = addr_q;
  assign bus.DataConfWr  = data_q;
  assign bus.ConfWr      = conf_wr_q;
  assign bus.DefConf     = def_conf_q;
  assign bus.RspValid    = rsp_valid_q;
  assign bus.RspData     = rsp_data_q;
  assign bus.Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_conf_bus_master.sv
// Randomized self-checking bench for conf_bus_master with a behavioural pixel-chain model.
module tb_conf_bus_master;
  localparam int unsigned AW = 12, DW = 8, S = 1, W = 2, RD = 4;
`ifdef CONF_RDBACK_CHECK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam logic [7:0] DEF = 8'hD7;

  logic Clk = 1'b0;
  logic Reset_B = 1'b0;
  always #5 Clk = ~Clk;

  conf_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  conf_bus_master #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(S), .WR_PULSE(W), .RD_LAT(RD)) dut (
    .Clk(Clk), .Reset_B(Reset_B), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int unsigned a);
    return (a == 16) ? 8'h81 : 8'(a * 7 + 3);
  endfunction

  // Pixel chain: stores strobed writes, returns data RD cycles after the address arrives.
  logic [7:0]  chain_mem [0:4095];
  logic [11:0] apipe [0:RD-1];
  bit          chain_ready = 1'b0;
  bit          corrupt = 1'b0;

  always @(posedge Clk) begin
    if (!chain_ready) begin
      for (int i = 0; i < 4096; i++) chain_mem[i] <= init_val(i);
      chain_ready <= 1'b1;
    end else if (bus.DefConf) begin
      for (int i = 0; i < 4096; i++) chain_mem[i] <= DEF;
    end else if (bus.ConfWr) begin
      chain_mem[bus.AddressConf] <= bus.DataConfWr;
    end
    apipe[0] <= bus.AddressConf;
    for (int i = 1; i < RD; i++) apipe[i] <= apipe[i-1];
  end

  assign bus.DataConfRd = chain_mem[apipe[RD-1]] ^ {7'b0, corrupt};

  logic [7:0] model_mem [0:4095];

  task automatic run_txn(input bit wr, input bit def, input logic [11:0] a, input logic [7:0] d,
                         input bit hold_v, input int unsigned abort_c);
    int unsigned L, w;
    bit          strobe_op, rb, in_win;
    logic [7:0]  exp_d;
    bit          exp_e;
    logic [24:0] exp_v;
    strobe_op = wr || def;
    rb        = RB && wr && !def;
    L         = strobe_op ? (S + W + 2 + (rb ? RD : 0)) : (S + RD + 1);
    if (!strobe_op)  exp_d = model_mem[a];
    else if (rb)     exp_d = d ^ {7'b0, corrupt};
    else             exp_d = 8'h00;
    exp_e = rb && corrupt;

    bus.ReqValid = 1'b1; bus.ReqWrite = wr; bus.ReqDefConf = def;
    bus.ReqAddr = a; bus.ReqData = d;
    w = 0;
    while (!bus.ReqReady && w < 40) begin @(negedge Clk); w++; end
    if (!bus.ReqReady) begin
      check("accept_timeout", 64'(bus.ReqReady), 64'd1);
      bus.ReqValid = 1'b0;
      return;
    end
    @(posedge Clk); #1;
    if (!hold_v) begin
      bus.ReqValid = 1'b0; bus.ReqAddr = 12'($urandom); bus.ReqData = 8'($urandom);
      bus.ReqWrite = 1'($urandom); bus.ReqDefConf = 1'($urandom);
    end

    for (int unsigned c = 1; c <= L; c++) begin
      @(negedge Clk);
      in_win = (c > S) && (c <= S + W);
      exp_v = {1'b0, 1'b1, strobe_op && !def && in_win, def && in_win, c == L, a, d};
      check($sformatf("cyc%0d", c),
            {bus.ReqReady, bus.Busy, bus.ConfWr, bus.DefConf, bus.RspValid, bus.AddressConf, bus.DataConfWr},
            exp_v);
      if (c == abort_c) begin
        #1 Reset_B = 1'b0; bus.ReqValid = 1'b0;
        #1 check("abort_async",
                 {bus.ReqReady, bus.Busy, bus.ConfWr, bus.DefConf, bus.RspValid, bus.AddressConf, bus.DataConfWr},
                 64'd0);
        repeat (3) begin
          @(negedge Clk);
          check("abort_norsp", {bus.RspValid, bus.ConfWr, bus.DefConf}, 64'd0);
        end
        Reset_B = 1'b1;
        #1 check("abort_rel_pre", 64'(bus.ReqReady), 64'd0);
        @(negedge Clk);
        check("abort_rel", {bus.ReqReady, bus.Busy, bus.RspValid}, 64'b100);
        return;
      end
      if (c == L) begin
        check("rsp_data", 64'(bus.RspData), 64'(exp_d));
        check("rsp_err", 64'(bus.RspErr), 64'(exp_e));
      end
    end

    if (def) for (int i = 0; i < 4096; i++) model_mem[i] = DEF;
    else if (wr) model_mem[a] = d;

    @(negedge Clk);
    check("idle", {bus.ReqReady, bus.Busy, bus.RspValid, bus.ConfWr, bus.DefConf}, 64'b10000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ra;
    int unsigned op, gap;
    for (int i = 0; i < 4096; i++) model_mem[i] = init_val(i);

    Reset_B = 1'b0;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqDefConf = 1'b0;
    bus.ReqAddr = 12'hFFF; bus.ReqData = 8'hFF;
    repeat (6) @(negedge Clk);
    check("reset_outs",
          {bus.ReqReady, bus.Busy, bus.ConfWr, bus.DefConf, bus.RspValid, bus.RspErr,
           bus.AddressConf, bus.DataConfWr, bus.RspData}, 64'd0);
    bus.ReqValid = 1'b0;
    Reset_B = 1'b1;
    #1 check("reset_rel_pre", 64'(bus.ReqReady), 64'd0);
    @(negedge Clk);
    check("reset_rel", {bus.ReqReady, bus.Busy}, 64'b10);

    run_txn(1'b1, 1'b0, 12'h2A5, 8'h3C, 1'b0, 0);
    run_txn(1'b0, 1'b0, 12'h010, 8'h00, 1'b0, 0);

    run_txn(1'b1, 1'b0, 12'h011, 8'hA1, 1'b1, 0);
    run_txn(1'b0, 1'b0, 12'h2A5, 8'h00, 1'b1, 0);
    run_txn(1'b1, 1'b0, 12'h012, 8'h5E, 1'b0, 0);

    run_txn(1'b1, 1'b1, 12'h123, 8'h55, 1'b0, 0);
    run_txn(1'b0, 1'b0, 12'h2A5, 8'h00, 1'b0, 0);

    run_txn(1'b1, 1'b0, 12'h0AA, 8'h99, 1'b0, 2);
    run_txn(1'b0, 1'b0, 12'h0AA, 8'h00, 1'b0, 0);

`ifdef CONF_RDBACK_CHECK_EN
    corrupt = 1'b1;
    run_txn(1'b1, 1'b0, 12'h033, 8'h44, 1'b0, 0);
    corrupt = 1'b0;
    run_txn(1'b1, 1'b0, 12'h034, 8'h45, 1'b0, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      ra = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
      run_txn(op < 5, op == 0, ra, 8'($urandom), 1'($urandom), 0);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        bus.ReqValid = 1'b0;
        repeat (gap) @(negedge Clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conf_bus_master.md
Name: conf_bus_master

Overview:
- Periphery-side initiator for the pixel-core configuration bus that is daisy-chained through the core columns: AddressConf, DataConfWr, ConfWr, DataConfRd and DefConf.
- Accepts single read/write requests from the global configuration logic over a valid/ready handshake.
- Sequences the bus with programmable setup, strobe-width and read-latency timing.
- Returns read data, or a write completion, on a one-cycle response strobe.

Parameters:
ADDR_W, 12, width of the pixel configuration address
DATA_W, 8, width of the configuration data
SETUP_CYC, 1, cycles that address/data are stable before the ConfWr strobe (>=1)
WR_PULSE, 2, ConfWr high time in cycles (>=1)
RD_LAT, 4, cycles from address launch to DataConfRd being valid at the column bottom (>=1)

Ports:
Clk  in  1  bus clock
Reset_B  in  1  asynchronous active-low reset
ReqValid  in  1  request present
ReqReady  out  1  block can accept a request
ReqWrite  in  1  1 = write, 0 = read
ReqAddr  in  ADDR_W  target pixel-region address
ReqData  in  DATA_W  write data
ReqDefConf  in  1  request-all-default; ignores address and data
RspValid  out  1  one-cycle completion strobe
RspData  out  DATA_W  captured read data; 0 for writes
RspErr  out  1  readback mismatch (optional feature only)
AddressConf  out  ADDR_W  bus address into the core chain
DataConfWr  out  DATA_W  bus write data
ConfWr  out  1  bus write strobe
DefConf  out  1  load-default-configuration strobe
DataConfRd  in  DATA_W  read data returned from the core chain
Busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync deassert inside the block): all outputs 0 and FSM in IDLE, except ReqReady=1 once reset is released.
- ReqReady=1 only in IDLE. A request is accepted on the cycle where ReqValid & ReqReady.
- Acceptance registers ReqAddr and ReqData into AddressConf and DataConfWr on the next edge. Both hold stable until the transaction ends. They are not cleared afterwards; they keep their last value.
- States:
  - IDLE: on accept, go to SETUP.
  - SETUP: counts SETUP_CYC cycles. Then, if write or DefConf, go to STROBE; if read, go to RDWAIT.
  - STROBE: ConfWr=1 (or DefConf=1 when ReqDefConf) for exactly WR_PULSE cycles, then go to HOLD.
  - HOLD: 1 cycle with strobes 0 and address/data held, then go to RESP.
  - RDWAIT: counts RD_LAT cycles, capturing DataConfRd into RspData on the final cycle, then go to RESP.
  - RESP: RspValid=1 for exactly 1 cycle, then go to IDLE. ReqReady returns to 1 the cycle after RESP.
- ConfWr and DefConf are registered, never both high, and glitch-free.
- Write latency, accept to RspValid: 1+SETUP_CYC+WR_PULSE+1+1 cycles; 6 with defaults.
- Read latency, accept to RspValid: 1+SETUP_CYC+RD_LAT+1 cycles; 7 with defaults.
- ReqDefConf has priority over ReqWrite. It uses the write timing with DefConf as the strobe, and ConfWr stays 0.
- RspData: 0 for write and DefConf responses; otherwise it holds its value until the next response.
- Counters are sized to $clog2(max param)+1 bits. There is no wrap: each counter reloads on every state entry.
- ReqValid arriving while busy is ignored until ReqReady=1, with no loss because the requester must hold it.
- Reset asserted mid-transaction: strobes drop immediately (async), no RspValid is issued, and the aborted transaction is not replayed.

Optional Feature:
- CONF_RDBACK_CHECK_EN defined:
  - After HOLD on a normal write (not DefConf), go through RDWAIT on the same address before RESP.
  - In RESP, RspErr = (captured DataConfRd != DataConfWr). RspData = the captured value.
  - Write latency becomes 1+SETUP_CYC+WR_PULSE+1+RD_LAT+1 (10 with defaults).
- Undefined: RspErr tied to 0 and no readback state is generated.

Test Plan:
- Reset: hold Reset_B=0, drive ReqValid=1 -> all bus outputs 0, RspValid 0. Release -> ReqReady=1 at the next edge.
- Write: ReqAddr=0x2A5, ReqData=0x3C, ReqWrite=1 -> AddressConf=0x2A5 and DataConfWr=0x3C from cycle 1; ConfWr high in cycles 2-3; RspValid in cycle 5 with RspData=0.
- Read: model chain returns 0x81 after 4 cycles, ReqAddr=0x010, ReqWrite=0 -> ConfWr never asserted; RspValid in cycle 6 with RspData=0x81.
- Back-to-back: ReqValid held high for 3 requests -> each accepted only when ReqReady=1; no overlap on ConfWr; 3 RspValid pulses in order.
- DefConf: ReqDefConf=1 with ReqWrite=1 -> DefConf high for 2 cycles; ConfWr stays 0; response as for a write.
- Reset during STROBE: Reset_B low in cycle 2 -> ConfWr falls asynchronously; no RspValid; next request completes normally. With CONF_RDBACK_CHECK_EN, a chain model that corrupts bit 0 -> RspErr=1 at cycle 9.
